// File: rtl/joycon_pkg.sv
// joycon_pkg: shared constants and types for the Joy-Con report packer.
//   SYNC0_C/SYNC1_C/LEN_C : frame header constants
//   FRAME_BYTES           : total bytes per frame including checksum
//   snap_t                : 136-bit snapshot of the Joy-Con state
//   IDX_*                 : byte positions inside a frame
`timescale 1ns/1ps
package joycon_pkg;

  localparam logic [7:0]  SYNC0_C     = 8'hA5;
  localparam logic [7:0]  SYNC1_C     = 8'h5A;
  localparam logic [7:0]  LEN_C       = 8'h11;
  localparam int unsigned FRAME_BYTES = 22;

  // rsvd pads the detected flag out to the full STATUS byte.
  typedef struct packed {
    logic [6:0]  rsvd;
    logic        detected;
    logic [15:0] btn;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic [15:0] gyro_x;
    logic [15:0] gyro_y;
    logic [15:0] gyro_z;
    logic [15:0] acc_x;
    logic [15:0] acc_y;
    logic [15:0] acc_z;
  } snap_t;

  localparam logic [4:0] IDX_SYNC0  = 5'd0;
  localparam logic [4:0] IDX_SYNC1  = 5'd1;
  localparam logic [4:0] IDX_SEQ    = 5'd2;
  localparam logic [4:0] IDX_LEN    = 5'd3;
  localparam logic [4:0] IDX_STATUS = 5'd4;
  localparam logic [4:0] IDX_BTN_L  = 5'd5;
  localparam logic [4:0] IDX_BTN_H  = 5'd6;
  localparam logic [4:0] IDX_STK_X  = 5'd7;
  localparam logic [4:0] IDX_STK_Y  = 5'd8;
  localparam logic [4:0] IDX_GX_L   = 5'd9;
  localparam logic [4:0] IDX_GX_H   = 5'd10;
  localparam logic [4:0] IDX_GY_L   = 5'd11;
  localparam logic [4:0] IDX_GY_H   = 5'd12;
  localparam logic [4:0] IDX_GZ_L   = 5'd13;
  localparam logic [4:0] IDX_GZ_H   = 5'd14;
  localparam logic [4:0] IDX_AX_L   = 5'd15;
  localparam logic [4:0] IDX_AX_H   = 5'd16;
  localparam logic [4:0] IDX_AY_L   = 5'd17;
  localparam logic [4:0] IDX_AY_H   = 5'd18;
  localparam logic [4:0] IDX_AZ_L   = 5'd19;
  localparam logic [4:0] IDX_AZ_H   = 5'd20;
  localparam logic [4:0] IDX_CHK    = 5'd21;

  // Bytes SEQ..AZ_H feed the checksum; sync bytes and CHK itself do not.
  function automatic logic in_chk_range(input logic [4:0] idx);
    return (idx >= IDX_SEQ) && (idx <= IDX_AZ_H);
  endfunction

endpackage

// File: rtl/joycon_snapshot_buf.sv
// joycon_snapshot_buf: pending/active snapshot banks.
//   clk, rst       : clock, synchronous active-high reset
//   i_capture      : accepted strobe, write i_snap into the pending bank
//   i_snap         : snapshot to capture
//   i_take         : move pending bank into active bank (only when pending)
//   o_pending      : pending bank holds an untransmitted snapshot
//   o_active       : snapshot currently being serialized
//   o_drop_count   : saturating count of overwritten pending snapshots
`timescale 1ns/1ps
module joycon_snapshot_buf
  import joycon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_capture,
  input  snap_t      i_snap,
  input  logic       i_take,
  output logic       o_pending,
  output snap_t      o_active,
  output logic [7:0] o_drop_count
);

  logic       r_pending;
  logic [7:0] r_drop_count;
  snap_t      r_pend_bank;
  snap_t      r_active_bank;

  // A capture that coincides with a take refills the slot just emptied,
  // so it is only a drop when the old snapshot is not leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (i_capture) begin
        r_pending <= 1'b1;
        if (r_pending && !i_take && (r_drop_count != 8'hFF))
          r_drop_count <= r_drop_count + 8'd1;
      end else if (i_take) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Data banks carry no reset; the pending flag qualifies their contents.
  always_ff @(posedge clk) begin
    if (i_capture) r_pend_bank <= i_snap;
    if (i_take)    r_active_bank <= r_pend_bank;
  end

  assign o_pending    = r_pending;
  assign o_active     = r_active_bank;
  assign o_drop_count = r_drop_count;

endmodule

// File: rtl/joycon_report_packer.sv
// joycon_report_packer: snapshots Joy-Con state on (decimated) update strobes
// and serializes it as a 22-byte framed, checksummed valid/ready byte stream.
//   clk, rst            : clock, synchronous active-high reset
//   joycon_detected     : link-up flag, captured into STATUS bit 0
//   botton_value        : 16-bit button bitmap
//   stick_x/stick_y     : 8-bit stick axes
//   gyro_x/y/z, acc_x/y/z : 16-bit IMU samples
//   state_update        : one-cycle strobe, data inputs valid with it
//   tx_data/tx_data_valid/tx_data_ready : output byte stream
//   drop_count          : saturating overwrite counter
//   busy                : frame in flight
`timescale 1ns/1ps
module joycon_report_packer
  import joycon_pkg::*;
#(
  parameter int unsigned DECIMATE = 1,
  parameter logic [7:0]  SYNC0    = SYNC0_C,
  parameter logic [7:0]  SYNC1    = SYNC1_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        joycon_detected,
  input  logic [15:0] botton_value,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic [15:0] acc_x,
  input  logic [15:0] acc_y,
  input  logic [15:0] acc_z,
  input  logic        state_update,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e     r_state;
  logic [7:0] r_dec_cnt;
  logic [4:0] r_idx;
  logic [7:0] r_seq;
  logic [7:0] r_chk;
  logic       r_tx_valid;
  logic       r_busy;

  logic       w_accept;
  logic       w_pending;
  logic       w_hs;
  logic       w_last_hs;
  logic       w_take;
  snap_t      w_snap;
  snap_t      w_active;
  logic [7:0] w_byte;

  assign w_accept  = state_update && (r_dec_cnt == 8'(DECIMATE - 1));
  assign w_snap    = {7'd0, joycon_detected, botton_value, stick_x, stick_y,
                      gyro_x, gyro_y, gyro_z, acc_x, acc_y, acc_z};
  assign w_hs      = r_tx_valid && tx_data_ready;
  assign w_last_hs = w_hs && (r_idx == IDX_CHK);
  // Load the next frame either from IDLE or straight off the final byte.
  assign w_take    = w_pending && ((r_state == ST_IDLE) || w_last_hs);

  joycon_snapshot_buf u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_capture    (w_accept),
    .i_snap       (w_snap),
    .i_take       (w_take),
    .o_pending    (w_pending),
    .o_active     (w_active),
    .o_drop_count (drop_count)
  );

  // Decimator: skipped strobes are simply ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_cnt <= 8'd0;
    end else if (state_update) begin
      r_dec_cnt <= w_accept ? 8'd0 : r_dec_cnt + 8'd1;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      IDX_SYNC0:  w_byte = SYNC0;
      IDX_SYNC1:  w_byte = SYNC1;
      IDX_SEQ:    w_byte = r_seq;
      IDX_LEN:    w_byte = LEN_C;
      IDX_STATUS: w_byte = {w_active.rsvd, w_active.detected};
      IDX_BTN_L:  w_byte = w_active.btn[7:0];
      IDX_BTN_H:  w_byte = w_active.btn[15:8];
      IDX_STK_X:  w_byte = w_active.stick_x;
      IDX_STK_Y:  w_byte = w_active.stick_y;
      IDX_GX_L:   w_byte = w_active.gyro_x[7:0];
      IDX_GX_H:   w_byte = w_active.gyro_x[15:8];
      IDX_GY_L:   w_byte = w_active.gyro_y[7:0];
      IDX_GY_H:   w_byte = w_active.gyro_y[15:8];
      IDX_GZ_L:   w_byte = w_active.gyro_z[7:0];
      IDX_GZ_H:   w_byte = w_active.gyro_z[15:8];
      IDX_AX_L:   w_byte = w_active.acc_x[7:0];
      IDX_AX_H:   w_byte = w_active.acc_x[15:8];
      IDX_AY_L:   w_byte = w_active.acc_y[7:0];
      IDX_AY_H:   w_byte = w_active.acc_y[15:8];
      IDX_AZ_L:   w_byte = w_active.acc_z[7:0];
      IDX_AZ_H:   w_byte = w_active.acc_z[15:8];
      IDX_CHK:    w_byte = r_chk;
      default:    w_byte = 8'h00;
    endcase
  end

  // Frame FSM: all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 5'd0;
      r_seq      <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state    <= ST_SEND;
            r_idx      <= 5'd0;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (r_idx == IDX_CHK) begin
              r_seq <= r_seq + 8'd1;
              r_idx <= 5'd0;
              if (!w_pending) begin
                r_state    <= ST_IDLE;
                r_tx_valid <= 1'b0;
                r_busy     <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Checksum accumulates sent bytes; cleared whenever a new frame loads.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_chk <= 8'd0;
    end else if (w_hs && in_chk_range(r_idx)) begin
      r_chk <= r_chk + w_byte;
    end
  end

  assign tx_data       = r_tx_valid ? w_byte : 8'h00;
  assign tx_data_valid = r_tx_valid;
  assign busy          = r_busy;

endmodule

// File: tb/tb_joycon_report_packer.sv
`timescale 1ns/1ps
module tb_joycon_report_packer;

  typedef logic [7:0] frame_t [22];

  logic        clk = 1'b0;
  logic        rst;
  logic        det;
  logic [15:0] btn, gx, gy, gz, ax, ay, az;
  logic [7:0]  sx, sy;
  logic        upd, upd4, ready;
  logic [7:0]  tx_data, tx_data4, drop, drop4;
  logic        tx_valid, tx_valid4, busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  joycon_report_packer #(.DECIMATE(1)) dut (
    .clk(clk), .rst(rst), .joycon_detected(det), .botton_value(btn),
    .stick_x(sx), .stick_y(sy), .gyro_x(gx), .gyro_y(gy), .gyro_z(gz),
    .acc_x(ax), .acc_y(ay), .acc_z(az), .state_update(upd),
    .tx_data(tx_data), .tx_data_valid(tx_valid), .tx_data_ready(ready),
    .drop_count(drop), .busy(busy)
  );

  joycon_report_packer #(.DECIMATE(4)) dut4 (
    .clk(clk), .rst(rst), .joycon_detected(det), .botton_value(btn),
    .stick_x(sx), .stick_y(sy), .gyro_x(gx), .gyro_y(gy), .gyro_z(gz),
    .acc_x(ax), .acc_y(ay), .acc_z(az), .state_update(upd4),
    .tx_data(tx_data4), .tx_data_valid(tx_valid4), .tx_data_ready(ready),
    .drop_count(drop4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k);
    logic [7:0] kk;
    kk  = k[7:0];
    det = kk[0];
    btn = {kk, ~kk};
    sx  = kk;
    sy  = kk ^ 8'h55;
    gx  = {8'h10, kk};
    gy  = {kk, 8'h20};
    gz  = 16'h3000 + {8'h00, kk};
    ax  = ~{kk, kk};
    ay  = {kk, 8'h01};
    az  = 16'h8000 | {8'h00, kk};
  endtask

  // Reference frame built from the bench's own current input values.
  task automatic build(input logic [7:0] seq, output frame_t f);
    logic [7:0] s;
    f = '{8'hA5, 8'h5A, seq, 8'h11, {7'd0, det}, btn[7:0], btn[15:8], sx, sy,
          gx[7:0], gx[15:8], gy[7:0], gy[15:8], gz[7:0], gz[15:8],
          ax[7:0], ax[15:8], ay[7:0], ay[15:8], az[7:0], az[15:8], 8'h00};
    s = 8'h00;
    for (int i = 2; i <= 20; i++) s = s + f[i];
    f[21] = s;
  endtask

  task automatic pulse(input bit sel);
    if (sel) upd4 = 1'b1; else upd = 1'b1;
    step();
    upd  = 1'b0;
    upd4 = 1'b0;
  endtask

  // Collect one frame; rnd toggles ready pseudo-randomly, sel picks dut4.
  task automatic recv_frame(input bit rnd, input bit sel, output frame_t f);
    int n, cyc;
    logic v, pv, pr;
    logic [7:0] d, pd;
    n = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00;
    f = '{default: 8'h00};
    while (n < 22 && cyc < 2000) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = sel ? tx_valid4 : tx_valid;
      d = sel ? tx_data4 : tx_data;
      if (pv && !pr) check("hold_data", d, pd);
      if (n > 0) check("mid_valid", 8'(v), 8'd1);
      if (v && ready) begin
        f[n] = d;
        n++;
      end
      pv = v; pr = ready; pd = d;
      step();
      cyc++;
    end
    check("frame_len", 8'(n), 8'd22);
    ready = 1'b1;
  endtask

  task automatic cmp_frame(input string tag, input frame_t got, input frame_t exp);
    for (int i = 0; i < 22; i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  frame_t t1, e1, e3, got;
  int vcnt;

  initial begin
    rst = 1'b1; upd = 1'b0; upd4 = 1'b0; ready = 1'b1;
    set_data(0);
    repeat (3) step();
    check("rst_valid", 8'(tx_valid), 8'd0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_drop", drop, 8'h00);
    check("rst_valid4", 8'(tx_valid4), 8'd0);
    check("rst_drop4", drop4, 8'h00);
    check("rst_busy4", 8'(busy4), 8'd0);
    rst = 1'b0;
    step();

    // Single frame with hand-computed bytes (CHK = 0xEB).
    det = 1'b1; btn = 16'h1234; sx = 8'h80; sy = 8'h7F;
    gx = 16'h0102; gy = 16'h0304; gz = 16'h0506;
    ax = 16'hFFFF; ay = 16'h0000; az = 16'h8001;
    t1 = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h01, 8'h34, 8'h12, 8'h80, 8'h7F,
           8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'hFF, 8'hFF, 8'h00,
           8'h00, 8'h01, 8'h80, 8'hEB};
    pulse(1'b0);
    check("lat_t1_valid", 8'(tx_valid), 8'd0);
    step();
    check("lat_t2_valid", 8'(tx_valid), 8'd1);
    check("lat_t2_sync0", tx_data, 8'hA5);
    check("lat_t2_busy", 8'(busy), 8'd1);
    recv_frame(1'b0, 1'b0, got);
    cmp_frame("single", got, t1);
    check("post_valid", 8'(tx_valid), 8'd0);
    check("post_busy", 8'(busy), 8'd0);

    // Backpressure: same data, SEQ now 01.
    build(8'h01, e1);
    pulse(1'b0);
    recv_frame(1'b1, 1'b0, got);
    cmp_frame("bp", got, e1);

    // Overrun: three strobes two cycles apart while the sink stalls.
    rst = 1'b1; step(); rst = 1'b0;
    ready = 1'b0;
    set_data(1); build(8'h00, e1);
    pulse(1'b0); step();
    set_data(2);
    pulse(1'b0); step();
    set_data(3); build(8'h01, e3);
    pulse(1'b0); step();
    check("ovr_drop", drop, 8'h01);
    check("ovr_stall_valid", 8'(tx_valid), 8'd1);
    check("ovr_stall_data", tx_data, 8'hA5);
    recv_frame(1'b0, 1'b0, got);
    cmp_frame("ovr_f0", got, e1);
    check("ovr_gap_valid", 8'(tx_valid), 8'd1);
    check("ovr_gap_sync0", tx_data, 8'hA5);
    recv_frame(1'b0, 1'b0, got);
    cmp_frame("ovr_f1", got, e3);
    check("ovr_drop_after", drop, 8'h01);
    check("ovr_idle", 8'(tx_valid), 8'd0);

    // Decimation by 4 on the second instance.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      set_data(i + 16);
      if (i % 4 == 0) build(8'(i / 4 - 1), e1);
      pulse(1'b1);
      if (i % 4 == 0) begin
        recv_frame(1'b0, 1'b1, got);
        cmp_frame($sformatf("dec%0d", i), got, e1);
      end else begin
        vcnt = 0;
        for (int c = 0; c < 50; c++) begin
          if (tx_valid4) vcnt++;
          step();
        end
        check($sformatf("dec_skip%0d", i), 8'(vcnt), 8'd0);
      end
    end
    vcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx_valid4 || tx_valid) vcnt++;
      step();
    end
    check("dec_tail", 8'(vcnt), 8'd0);

    // SEQ wrap over 257 frames.
    rst = 1'b1; step(); rst = 1'b0;
    for (int f = 0; f <= 256; f++) begin
      set_data(f);
      build(f[7:0], e1);
      pulse(1'b0);
      recv_frame(1'b0, 1'b0, got);
      check($sformatf("wrap_seq%0d", f), got[2], e1[2]);
      check($sformatf("wrap_chk%0d", f), got[21], e1[21]);
    end
    check("wrap_last_seq", got[2], 8'h00);

    // Drop counter saturation with a continuously stalled sink.
    ready = 1'b0;
    upd = 1'b1;
    repeat (256) step();
    check("sat_fe", drop, 8'hFE);
    repeat (46) step();
    check("sat_ff", drop, 8'hFF);
    upd = 1'b0;
    step();
    check("sat_hold", drop, 8'hFF);

    // Reset mid-frame at byte 10 (current frame SEQ 01, data of set_data(256)).
    build(8'h01, e1);
    ready = 1'b1;
    repeat (10) step();
    check("mid_byte10", tx_data, e1[10]);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 8'(tx_valid), 8'd0);
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_drop", drop, 8'h00);
    check("mid_rst_data", tx_data, 8'h00);
    rst = 1'b0;
    repeat (3) step();
    check("mid_quiet", 8'(tx_valid), 8'd0);
    set_data(77);
    build(8'h00, e1);
    pulse(1'b0);
    recv_frame(1'b0, 1'b0, got);
    cmp_frame("after_rst", got, e1);
    check("after_rst_drop", drop, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
